// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with one-deep holding register
//
// Purpose: accepts WIDTH-bit words over a valid/ready handshake and emits them
// one bit per clock, feeding a downstream SIPO. A holding register lets the
// next word queue behind the one being shifted, so back-to-back words stream
// with no idle cycle between them.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   data_in    - parallel word to serialize
//   load_valid - data_in is valid this cycle
//   load_ready - a word can be accepted this cycle
//   data_out   - registered serial bit
//   bit_valid  - registered; data_out carries a word bit
//   first_bit  - registered; data_out is the first serial bit of a word
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             first_bit
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               data_out_q, data_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               first_bit_q, first_bit_d;

  logic               accept;
  logic               is_free;

  // Ready never depends on load_valid, only on registered state and reset.
  assign load_ready = !rst && !hold_full_q;
  assign accept     = load_valid && load_ready;

  // The shifter can take a new word on this edge when it is empty or its last
  // bit is currently on the line.
  assign is_free = (state_q == IDLE) || (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (is_free) begin
      if (hold_full_q) begin
        // Held word moves into the shifter; hold refills only if a word
        // arrives on this same edge.
        shift_d     = hold_q;
        state_d     = SHIFT;
        cnt_d       = '0;
        hold_full_d = accept;
        if (accept) begin
          hold_d = data_in;
        end
      end else if (accept) begin
        // Bypass: straight into the shifter, no gap after the previous word.
        shift_d = data_in;
        state_d = SHIFT;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      cnt_d   = cnt_q + CW'(1);
      // The bit to emit is always kept at the output end of the shifter.
      shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
      if (accept) begin
        hold_d      = data_in;
        hold_full_d = 1'b1;
      end
    end

    // Outputs are registered from next state so the first bit appears in the
    // cycle right after the edge that loads the shifter.
    bit_valid_d = (state_d == SHIFT);
    first_bit_d = (state_d == SHIFT) && (cnt_d == '0);
    data_out_d  = 1'b0;
    if (state_d == SHIFT) begin
      data_out_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      data_out_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      first_bit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      data_out_q  <= data_out_d;
      bit_valid_q <= bit_valid_d;
      first_bit_q <= first_bit_d;
    end
  end

  assign data_out  = data_out_q;
  assign bit_valid = bit_valid_q;
  assign first_bit = first_bit_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (MSB-first and LSB-first)
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         ready_m, dout_m, bv_m, fb_m;
  logic         ready_l, dout_l, bv_l, fb_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .data_out(dout_m), .bit_valid(bv_m), .first_bit(fb_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .data_out(dout_l), .bit_valid(bv_l), .first_bit(fb_l)
  );

  // Reference model: words waiting behind the shifter, plus the word on the
  // line and which serial position of it is being sent.
  logic [W-1:0] wait_q[$];
  logic [W-1:0] cur;
  bit           active = 0;
  int           idx = 0;
  bit           acc;

  // Downstream SIPO view: every accepted word must come back out, in order.
  logic [W-1:0] sb_q[$];
  logic [W-1:0] col_m, col_l;
  int           col_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [W-1:0] d);
    bit exp_ready;
    logic [W-1:0] w;
    rst = r; load_valid = v; data_in = d;
    #1;
    exp_ready = !r && (wait_q.size() == 0);
    check("load_ready_msb", 32'(ready_m), 32'(exp_ready));
    check("load_ready_lsb", 32'(ready_l), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    if (r) begin
      wait_q.delete();
      sb_q.delete();
      active = 0;
      idx    = 0;
      col_n  = 0;
    end else begin
      if (acc) begin
        wait_q.push_back(d);
        sb_q.push_back(d);
      end
      if (active && idx < W - 1) begin
        idx++;
      end else if (wait_q.size() > 0) begin
        cur    = wait_q.pop_front();
        idx    = 0;
        active = 1;
      end else begin
        active = 0;
      end
    end
    @(negedge clk);
    check("bit_valid_msb", 32'(bv_m), 32'(active));
    check("bit_valid_lsb", 32'(bv_l), 32'(active));
    check("first_bit_msb", 32'(fb_m), 32'(active && idx == 0));
    check("first_bit_lsb", 32'(fb_l), 32'(active && idx == 0));
    check("data_out_msb", 32'(dout_m), active ? 32'(cur[W-1-idx]) : 32'd0);
    check("data_out_lsb", 32'(dout_l), active ? 32'(cur[idx]) : 32'd0);
    if (!r && bv_m === 1'b1) begin
      if (fb_m === 1'b1) col_n = 0;
      col_m = {col_m[W-2:0], dout_m};
      col_l = {dout_l, col_l[W-1:1]};
      col_n++;
      if (col_n == W) begin
        col_n = 0;
        if (sb_q.size() == 0) begin
          check("sipo_word_unexpected", 32'd1, 32'd0);
        end else begin
          w = sb_q.pop_front();
          check("sipo_word_msb", 32'(col_m), 32'(w));
          check("sipo_word_lsb", 32'(col_l), 32'(w));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 15));
  endtask

  logic [W-1:0] bp_words[3];
  int           bp_i;
  int           guard;

  initial begin
    rst = 1'b1; load_valid = 1'b0; data_in = '0;
    @(negedge clk);
    // reset / idle
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF);
    idle(3);

    // single word, plus LSB-first view of 0001 in the second instance
    step(1'b0, 1'b1, 4'b1001);
    idle(5);
    step(1'b0, 1'b1, 4'b0001);
    idle(5);

    // back-to-back
    step(1'b0, 1'b1, 4'b1010);
    step(1'b0, 1'b1, 4'b0110);
    idle(9);

    // backpressure: load_valid held high, each word offered until accepted
    bp_words[0] = 4'b1100; bp_words[1] = 4'b0011; bp_words[2] = 4'b1111;
    bp_i = 0; guard = 0;
    while (bp_i < 3 && guard < 40) begin
      step(1'b0, 1'b1, bp_words[bp_i]);
      if (acc) bp_i++;
      guard++;
    end
    check("backpressure_all_accepted", 32'(bp_i), 32'd3);
    idle(14);

    // reset mid-word at cnt=2 with a word held
    step(1'b0, 1'b1, 4'b1111);
    step(1'b0, 1'b1, 4'b1010);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'b0101);
    idle(6);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15));
    end
    idle(12);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer that sits directly upstream of the 4-bit SIPO deserializer and drives its serial `data_in`. It accepts parallel words over a valid/ready handshake and emits them one bit per clock, with a bit-valid strobe and a word-start marker. A one-deep holding register allows back-to-back words to stream with no idle gap.

## Interface
- `WIDTH`, default 4: word width in bits. Must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  reset: synchronous and active-high
- `data_in`  input  WIDTH  parallel word to serialize
- `load_valid`  input  1  `data_in` is valid this cycle
- `load_ready`  output  1  block can accept a word this cycle
- `data_out`  output  1  serial bit, registered; connects to the SIPO's `data_in`
- `bit_valid`  output  1  `data_out` carries a word bit this cycle, registered
- `first_bit`  output  1  `data_out` is bit 0 of the serial sequence of a word, registered

## Operation
- Accept: the word is taken on a rising edge where `load_valid && load_ready`.
- `load_ready = !rst && !hold_full`. This is combinational from registered state, with no dependence on `load_valid`.
- State machine: IDLE (shifter empty) and SHIFT (shifter holds a word; bit counter `cnt` runs 0..WIDTH-1).
- `free` = IDLE, or SHIFT with `cnt == WIDTH-1` (last bit on the line this cycle).
- At each edge when `free`:
  - hold full: load the shifter from hold, go to SHIFT with `cnt=0`. Hold takes the accepted word if there is one, otherwise it empties.
  - hold empty and accept: load the shifter directly from `data_in` (bypass), go to SHIFT with `cnt=0`.
  - otherwise: go to IDLE.
- At each edge when not `free`: the accepted word goes to hold (`hold_full=1`), and `cnt` increments.
- Output registers:
  - `bit_valid=1` in every SHIFT cycle.
  - `first_bit=1` only when `cnt==0`.
  - `data_out` = current bit per `MSB_FIRST`.
  - In IDLE: `data_out=0`, `bit_valid=0`, `first_bit=0`.
- Word order is strictly FIFO: no word is dropped, duplicated or reordered.
- `data_in` does not need to be held stable after its accept edge.

## Timing
- Reset values:
  - `data_out=0`, `bit_valid=0`, `first_bit=0`, `load_ready=0` while `rst` is high.
  - After reset: state IDLE, `hold_full=0`, `cnt=0`. `load_ready=1` in the first cycle after `rst` falls.
- Latency: accept at edge N puts the first bit on `data_out` in the cycle after edge N, when the shifter is free.
- Bit k of a word is on `data_out` exactly k cycles after its first bit, so one word occupies WIDTH consecutive cycles.
- Throughput: with `load_valid` held high, output is continuous, with `bit_valid` high every cycle and `first_bit` every WIDTH cycles.
- Backpressure: while shifting with hold full, `load_ready=0`. It returns to 1 in the cycle after the hold-to-shifter transfer, unless a word was accepted on that same transfer edge.
- Simultaneous events: accept on the last-bit edge with hold empty takes the bypass path, with no gap.
- Reset mid-word (any `cnt`): the next edge aborts the word and clears hold. The held word is discarded and outputs return to their reset values.
- `rst` has priority over `load_valid`.

## Test plan
- Reset/idle:
  - Stimulus: `rst=1` for 2 cycles, then `load_valid=0`.
  - Required: `data_out=0`, `bit_valid=0`, `first_bit=0`; `load_ready=0` during reset and 1 after.
- Single word, MSB_FIRST=1:
  - Stimulus: accept `4'b1001`.
  - Required: `data_out` = 1,0,0,1 on 4 cycles with `bit_valid=1` and `first_bit` only on the first, then idle.
  - Required: a downstream SIPO then holds `4'b1001`.
- Back-to-back:
  - Stimulus: accept `4'b1010` then `4'b0110` on consecutive handshakes.
  - Required: 8 gap-free bits 1,0,1,0,0,1,1,0, with `first_bit` on bits 0 and 4.
- Backpressure:
  - Stimulus: hold `load_valid=1` with words A=`1100`, B=`0011`, C=`1111`.
  - Required: `load_ready=0` while B sits in hold; no word lost; output is A,B,C contiguous.
- MSB_FIRST=0:
  - Stimulus: accept `4'b0001`.
  - Required: `data_out` = 1,0,0,0.
- Reset mid-word:
  - Stimulus: accept `4'b1111` and a held `4'b1010`, then assert `rst` at `cnt=2`.
  - Required: outputs are 0 the next cycle and `hold_full` is cleared.
  - Required: after release, a new `4'b0101` serializes cleanly, with `first_bit` on its first bit.
